// File: rtl/truth_table_scanner.sv
// Exhaustive tester for a 4-input combinational function block: steps vec through 0..15,
// samples f_in after SETTLE cycles per vector, and compares the table against EXPECTED.
module truth_table_scanner #(
  parameter logic [15:0] EXPECTED = 16'h0727,
  parameter logic [15:0] DC_MASK  = 16'h0000,
  parameter int          SETTLE   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        f_in,
  output logic [3:0]  vec,
  output logic        busy,
  output logic        done,
  output logic [15:0] tbl,
  output logic        pass,
  output logic [3:0]  fail_idx,
  output logic [4:0]  fail_cnt,
  output logic [1:0]  dbg_state
);

  // Handshake: start is a level request, accepted on a rising edge while IDLE (or on the
  // DONE exit edge); done is a one-cycle pulse with all result outputs valid in that cycle.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [3:0]  vec_q, vec_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] scan_q, scan_d;
  logic [15:0] tbl_q, tbl_d;
  logic        pass_q, pass_d;
  logic [3:0]  fail_idx_q, fail_idx_d;
  logic [4:0]  fail_cnt_q, fail_cnt_d;

  logic [15:0] tbl_sampled;
  logic [15:0] mismatch;
  logic [4:0]  m_cnt;
  logic [3:0]  m_idx;

  // Table as it will look once the current vector's sample is written in.
  always_comb begin
    tbl_sampled        = scan_q;
    tbl_sampled[vec_q] = f_in;
    mismatch           = (tbl_sampled ^ EXPECTED) & ~DC_MASK;
    m_cnt              = '0;
    m_idx              = '0;
    for (int i = 0; i < 16; i++) begin
      m_cnt = m_cnt + 5'(mismatch[i]);
    end
    for (int i = 15; i >= 0; i--) begin
      if (mismatch[i]) m_idx = 4'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    scan_d     = scan_q;
    tbl_d      = tbl_q;
    pass_d     = pass_q;
    fail_idx_d = fail_idx_q;
    fail_cnt_d = fail_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          vec_d   = '0;
          cnt_d   = '0;
          scan_d  = '0;
        end
      end
      SCAN: begin
        if (cnt_q == LAST_CNT) begin
          scan_d = tbl_sampled;
          vec_d  = vec_q + 4'd1;
          cnt_d  = '0;
          if (vec_q == 4'd15) begin
            state_d    = DONE;
            tbl_d      = tbl_sampled;
            pass_d     = (mismatch == 16'h0000);
            fail_cnt_d = m_cnt;
            fail_idx_d = m_idx;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        // The DONE exit edge doubles as the IDLE acceptance edge, giving a
        // 16*SETTLE+1 start-to-start period when start is held high.
        state_d = IDLE;
        if (start) begin
          state_d = SCAN;
          vec_d   = '0;
          cnt_d   = '0;
          scan_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      cnt_q      <= '0;
      scan_q     <= '0;
      tbl_q      <= '0;
      pass_q     <= 1'b0;
      fail_idx_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      cnt_q      <= cnt_d;
      scan_q     <= scan_d;
      tbl_q      <= tbl_d;
      pass_q     <= pass_d;
      fail_idx_q <= fail_idx_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign vec       = vec_q;
  assign busy      = (state_q == SCAN);
  assign done      = (state_q == DONE);
  assign tbl       = tbl_q;
  assign pass      = pass_q;
  assign fail_idx  = fail_idx_q;
  assign fail_cnt  = fail_cnt_q;
  assign dbg_state = state_q;

endmodule
